ssd1306_spi_decoder: RTL and testbench

- Sits between the atmega32u4 OLED SPI pins (oled_clk, oled_data, oled_dc) and the video pixel generator.
- Deserialises the SPI stream and decodes the SSD1306 command subset used by Arduboy software.
- Maintains the display write pointer and issues one byte write per data byte into the 128x64 (8-page) framebuffer read by the video generator.
- Runs in the clk_sys domain; SPI inputs are asynchronous to it.

---
 rtl/ssd1306_spi_decoder.sv | 272 +++++++++++++++++++++++++++
 tb/tb_ssd1306_spi_decoder.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ssd1306_spi_decoder.sv
// rtl/ssd1306_spi_decoder.sv - SSD1306 SPI deserialiser, command decoder and framebuffer write pointer.
module ssd1306_spi_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1024,
    parameter int COLS        = 128,
    parameter int PAGES       = 8
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       oled_clk,
    input  logic       oled_data,
    input  logic       oled_dc,
    output logic       fb_we,
    output logic [9:0] fb_addr,
    output logic [7:0] fb_data,
    output logic       display_on,
    output logic       invert,
    output logic       frame_done
);

    localparam int         IW        = $clog2(TIMEOUT + 1);
    localparam logic [6:0] COL_LAST  = 7'(COLS - 1);
    localparam logic [2:0] PAGE_LAST = 3'(PAGES - 1);

    typedef enum logic [2:0] {
        S_CMD,
        S_MODE,
        S_COLS,
        S_COLE,
        S_PAGS,
        S_PAGE,
        S_SKIP
    } state_t;

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_data_sync;
    logic [SYNC_STAGES-1:0] r_dc_sync;
    logic                   r_clk_d;
    logic                   r_rise;
    logic                   r_rise_data;
    logic                   r_rise_dc;
    logic [2:0]             r_bit_cnt;
    logic [7:0]             r_shift;
    logic [IW-1:0]          r_idle;
    logic                   r_byte_valid;
    logic [7:0]             r_byte;
    logic                   r_byte_dc;

    logic                   w_rise;
    logic                   w_timeout;

    assign w_rise    = r_clk_sync[SYNC_STAGES-1] & ~r_clk_d;
    assign w_timeout = !r_rise && (r_idle == IW'(TIMEOUT));

    // The registered edge pulse carries its aligned data/dc bit into the shifter.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_clk_sync   <= '0;
            r_data_sync  <= '0;
            r_dc_sync    <= '0;
            r_clk_d      <= 1'b0;
            r_rise       <= 1'b0;
            r_rise_data  <= 1'b0;
            r_rise_dc    <= 1'b0;
            r_bit_cnt    <= 3'd0;
            r_shift      <= 8'd0;
            r_idle       <= '0;
            r_byte_valid <= 1'b0;
            r_byte       <= 8'd0;
            r_byte_dc    <= 1'b0;
        end else begin
            r_clk_sync   <= {r_clk_sync[SYNC_STAGES-2:0], oled_clk};
            r_data_sync  <= {r_data_sync[SYNC_STAGES-2:0], oled_data};
            r_dc_sync    <= {r_dc_sync[SYNC_STAGES-2:0], oled_dc};
            r_clk_d      <= r_clk_sync[SYNC_STAGES-1];
            r_rise       <= w_rise;
            r_rise_data  <= r_data_sync[SYNC_STAGES-1];
            r_rise_dc    <= r_dc_sync[SYNC_STAGES-1];
            r_byte_valid <= 1'b0;
            if (r_rise) begin
                r_shift   <= {r_shift[6:0], r_rise_data};
                r_bit_cnt <= r_bit_cnt + 3'd1;
                r_idle    <= '0;
                if (r_bit_cnt == 3'd7) begin
                    r_byte_valid <= 1'b1;
                    r_byte       <= {r_shift[6:0], r_rise_data};
                    r_byte_dc    <= r_rise_dc;
                end
            end else if (w_timeout) begin
                r_bit_cnt <= 3'd0;
                r_shift   <= 8'd0;
            end else begin
                r_idle <= r_idle + IW'(1);
            end
        end
    end

    state_t     r_state;
    logic [1:0] r_mode;
    logic [6:0] r_col;
    logic [2:0] r_page;
    logic [6:0] r_col_start;
    logic [6:0] r_col_end;
    logic [2:0] r_page_start;
    logic [2:0] r_page_end;
    logic       r_display_on;
    logic       r_invert;
    logic       r_fb_we;
    logic [9:0] r_fb_addr;
    logic [7:0] r_fb_data;
    logic       r_frame_done;

    state_t     w_state_nx;
    logic [1:0] w_mode_nx;
    logic [6:0] w_col_nx;
    logic [2:0] w_page_nx;
    logic [6:0] w_col_start_nx;
    logic [6:0] w_col_end_nx;
    logic [2:0] w_page_start_nx;
    logic [2:0] w_page_end_nx;
    logic       w_display_on_nx;
    logic       w_invert_nx;
    logic       w_fb_we_nx;
    logic [9:0] w_fb_addr_nx;
    logic [7:0] w_fb_data_nx;
    logic       w_frame_done_nx;
    logic       w_col_wrap;
    logic       w_page_wrap;

    assign w_col_wrap  = (r_col == r_col_end) || (r_col == COL_LAST);
    assign w_page_wrap = (r_page == r_page_end) || (r_page == PAGE_LAST);

    always_comb begin
        w_state_nx      = r_state;
        w_mode_nx       = r_mode;
        w_col_nx        = r_col;
        w_page_nx       = r_page;
        w_col_start_nx  = r_col_start;
        w_col_end_nx    = r_col_end;
        w_page_start_nx = r_page_start;
        w_page_end_nx   = r_page_end;
        w_display_on_nx = r_display_on;
        w_invert_nx     = r_invert;
        w_fb_we_nx      = 1'b0;
        w_fb_addr_nx    = r_fb_addr;
        w_fb_data_nx    = r_fb_data;
        w_frame_done_nx = 1'b0;
        if (r_byte_valid) begin
            if (r_byte_dc) begin
                // A data byte abandons any half-received command argument.
                w_fb_we_nx   = 1'b1;
                w_fb_addr_nx = {r_page, r_col};
                w_fb_data_nx = r_byte;
                w_state_nx   = S_CMD;
                case (r_mode)
                    2'd0: begin
                        if (w_col_wrap) begin
                            w_col_nx        = r_col_start;
                            w_page_nx       = w_page_wrap ? r_page_start : r_page + 3'd1;
                            w_frame_done_nx = w_page_wrap;
                        end else begin
                            w_col_nx = r_col + 7'd1;
                        end
                    end
                    2'd1: begin
                        if (w_page_wrap) begin
                            w_page_nx       = r_page_start;
                            w_col_nx        = w_col_wrap ? r_col_start : r_col + 7'd1;
                            w_frame_done_nx = w_col_wrap;
                        end else begin
                            w_page_nx = r_page + 3'd1;
                        end
                    end
                    default: w_col_nx = (r_col == COL_LAST) ? 7'd0 : r_col + 7'd1;
                endcase
            end else begin
                case (r_state)
                    S_CMD: begin
                        if (r_byte == 8'h20) begin
                            w_state_nx = S_MODE;
                        end else if (r_byte == 8'h21) begin
                            w_state_nx = S_COLS;
                        end else if (r_byte == 8'h22) begin
                            w_state_nx = S_PAGS;
                        end else if (r_byte[7:3] == 5'b10110) begin
                            w_page_nx = r_byte[2:0];
                        end else if (r_byte[7:4] == 4'h0) begin
                            w_col_nx = {r_col[6:4], r_byte[3:0]};
                        end else if (r_byte[7:3] == 5'b00010) begin
                            w_col_nx = {r_byte[2:0], r_col[3:0]};
                        end else begin
                            case (r_byte)
                                8'hA6: w_invert_nx     = 1'b0;
                                8'hA7: w_invert_nx     = 1'b1;
                                8'hAE: w_display_on_nx = 1'b0;
                                8'hAF: w_display_on_nx = 1'b1;
                                8'h81, 8'h8D, 8'hA8, 8'hD3,
                                8'hD5, 8'hD9, 8'hDA, 8'hDB: w_state_nx = S_SKIP;
                                default: ;
                            endcase
                        end
                    end
                    S_MODE: begin
                        w_mode_nx  = (r_byte[1:0] == 2'd3) ? 2'd2 : r_byte[1:0];
                        w_state_nx = S_CMD;
                    end
                    S_COLS: begin
                        w_col_start_nx = r_byte[6:0];
                        w_col_nx       = r_byte[6:0];
                        w_state_nx     = S_COLE;
                    end
                    S_COLE: begin
                        w_col_end_nx = r_byte[6:0];
                        w_state_nx   = S_CMD;
                    end
                    S_PAGS: begin
                        w_page_start_nx = r_byte[2:0];
                        w_page_nx       = r_byte[2:0];
                        w_state_nx      = S_PAGE;
                    end
                    S_PAGE: begin
                        w_page_end_nx = r_byte[2:0];
                        w_state_nx    = S_CMD;
                    end
                    default: w_state_nx = S_CMD;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state      <= S_CMD;
            r_mode       <= 2'd2;
            r_col        <= 7'd0;
            r_page       <= 3'd0;
            r_col_start  <= 7'd0;
            r_col_end    <= COL_LAST;
            r_page_start <= 3'd0;
            r_page_end   <= PAGE_LAST;
            r_display_on <= 1'b0;
            r_invert     <= 1'b0;
            r_fb_we      <= 1'b0;
            r_fb_addr    <= 10'd0;
            r_fb_data    <= 8'd0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_timeout ? S_CMD : w_state_nx;
            r_mode       <= w_mode_nx;
            r_col        <= w_col_nx;
            r_page       <= w_page_nx;
            r_col_start  <= w_col_start_nx;
            r_col_end    <= w_col_end_nx;
            r_page_start <= w_page_start_nx;
            r_page_end   <= w_page_end_nx;
            r_display_on <= w_display_on_nx;
            r_invert     <= w_invert_nx;
            r_fb_we      <= w_fb_we_nx;
            r_fb_addr    <= w_fb_addr_nx;
            r_fb_data    <= w_fb_data_nx;
            r_frame_done <= w_frame_done_nx;
        end
    end

    assign fb_we      = r_fb_we;
    assign fb_addr    = r_fb_addr;
    assign fb_data    = r_fb_data;
    assign display_on = r_display_on;
    assign invert     = r_invert;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_ssd1306_spi_decoder.sv
// tb/tb_ssd1306_spi_decoder.sv - self-checking bench for ssd1306_spi_decoder.
module tb_ssd1306_spi_decoder;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       oled_clk = 1'b0;
    logic       oled_data = 1'b0;
    logic       oled_dc = 1'b0;
    logic       fb_we;
    logic [9:0] fb_addr;
    logic [7:0] fb_data;
    logic       display_on;
    logic       invert;
    logic       frame_done;

    ssd1306_spi_decoder #(
        .SYNC_STAGES(2),
        .TIMEOUT(1024),
        .COLS(128),
        .PAGES(8)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .oled_clk(oled_clk),
        .oled_data(oled_data),
        .oled_dc(oled_dc),
        .fb_we(fb_we),
        .fb_addr(fb_addr),
        .fb_data(fb_data),
        .display_on(display_on),
        .invert(invert),
        .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int addr;
        int data;
        bit fd;
    } wr_t;

    wr_t exp_q[$];
    wr_t e;
    int  obs_addr[$];
    int  fd_idx = -1;
    int  t0 = 0;
    int  lat = -1;
    int  n_checks = 0;
    int  n_errors = 0;

    int  m_state, m_mode, m_col, m_page, m_cs, m_ce, m_ps, m_pe;
    bit  m_disp, m_inv;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_state = 0; m_mode = 2; m_col = 0; m_page = 0;
        m_cs = 0; m_ce = 127; m_ps = 0; m_pe = 7;
        m_disp = 0; m_inv = 0;
    endfunction

    // Reference behaviour: pointer as integer column/page, writes queued in order.
    task automatic model_byte(input logic [7:0] b, input logic dc);
        int  bv;
        wr_t w;
        bv = int'(b);
        if (dc) begin
            w.addr = m_page * 128 + m_col;
            w.data = bv;
            w.fd   = 0;
            m_state = 0;
            if (m_mode == 2) begin
                m_col = (m_col + 1) % 128;
            end else if (m_mode == 0) begin
                if (m_col == m_ce || m_col == 127) begin
                    m_col = m_cs;
                    if (m_page == m_pe || m_page == 7) begin m_page = m_ps; w.fd = 1; end
                    else m_page = m_page + 1;
                end else m_col = m_col + 1;
            end else begin
                if (m_page == m_pe || m_page == 7) begin
                    m_page = m_ps;
                    if (m_col == m_ce || m_col == 127) begin m_col = m_cs; w.fd = 1; end
                    else m_col = m_col + 1;
                end else m_page = m_page + 1;
            end
            exp_q.push_back(w);
        end else begin
            case (m_state)
                0: begin
                    if (bv == 32) m_state = 1;
                    else if (bv == 33) m_state = 2;
                    else if (bv == 34) m_state = 4;
                    else if (bv >= 176 && bv <= 183) m_page = bv - 176;
                    else if (bv < 16) m_col = (m_col / 16) * 16 + bv;
                    else if (bv >= 16 && bv <= 23) m_col = (bv - 16) * 16 + m_col % 16;
                    else if (bv == 166) m_inv = 0;
                    else if (bv == 167) m_inv = 1;
                    else if (bv == 174) m_disp = 0;
                    else if (bv == 175) m_disp = 1;
                    else if (bv inside {129, 141, 168, 211, 213, 217, 218, 219}) m_state = 6;
                end
                1: begin m_mode = (bv % 4 == 3) ? 2 : bv % 4; m_state = 0; end
                2: begin m_cs = bv % 128; m_col = m_cs; m_state = 3; end
                3: begin m_ce = bv % 128; m_state = 0; end
                4: begin m_ps = bv % 8; m_page = m_ps; m_state = 5; end
                5: begin m_pe = bv % 8; m_state = 0; end
                default: m_state = 0;
            endcase
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic dc, input int nbits = 8);
        if (nbits == 8) model_byte(b, dc);
        for (int i = 7; i >= 8 - nbits; i--) begin
            @(negedge clock);
            oled_data = b[i];
            oled_dc   = dc;
            oled_clk  = 1'b0;
            @(negedge clock);
            @(negedge clock);
            oled_clk = 1'b1;
            if (i == 0) t0 = cyc + 1;
            @(negedge clock);
            @(negedge clock);
        end
        @(negedge clock);
        oled_clk = 1'b0;
    endtask

    task automatic do_reset();
        oled_clk = 1'b0;
        @(negedge clock);
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        model_reset();
        exp_q.delete();
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        repeat (4) @(negedge clock);
        check(name, exp_q.size(), 0);
    endtask

    task automatic new_group();
        obs_addr.delete();
        fd_idx = -1;
    endtask

    always @(negedge clock) begin
        if (reset_n) begin
            if (fb_we) begin
                obs_addr.push_back(int'(fb_addr));
                if (frame_done) fd_idx = obs_addr.size() - 1;
                lat = cyc - t0;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_write: addr %0d data %0d", fb_addr, fb_data);
                end else begin
                    e = exp_q.pop_front();
                    if (int'(fb_addr) !== e.addr || int'(fb_data) !== e.data || frame_done !== e.fd) begin
                        n_errors++;
                        $display("FAIL write: got addr %0d data %0d fd %0d, expected addr %0d data %0d fd %0d",
                                 fb_addr, fb_data, frame_done, e.addr, e.data, e.fd);
                    end
                end
            end else if (frame_done) begin
                n_checks++;
                n_errors++;
                $display("FAIL frame_done_without_we: got 1, expected 0");
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time bound");
        $fatal(1);
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clock);
        check("reset_fb_we", fb_we, 0);
        check("reset_fb_addr", fb_addr, 0);
        check("reset_fb_data", fb_data, 0);
        check("reset_display_on", display_on, 0);
        check("reset_invert", invert, 0);
        check("reset_frame_done", frame_done, 0);
        do_reset();

        new_group();
        send_byte(8'hAF, 1'b0);
        send_byte(8'hA7, 1'b0);
        drain("drain_cmds");
        check("display_on_af", display_on, 1);
        check("invert_a7", invert, 1);
        send_byte(8'hA6, 1'b0);
        send_byte(8'h81, 1'b0);
        send_byte(8'hAE, 1'b0);
        drain("drain_skip");
        check("invert_a6", invert, 0);
        check("skip_arg_ignored", display_on, 1);
        check("no_writes_for_cmds", obs_addr.size(), 0);

        send_byte(8'h21, 1'b0);
        send_byte(8'h33, 1'b1);
        send_byte(8'hAE, 1'b0);
        drain("drain_abandon");
        check("abandon_then_cmd", display_on, 0);
        check("abandon_model", display_on, m_disp);

        do_reset();
        new_group();
        send_byte(8'h20, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h21, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h7F, 1'b0);
        send_byte(8'h22, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h07, 1'b0);
        for (int i = 0; i < 1024; i++) send_byte(8'(i), 1'b1);
        send_byte(8'hEE, 1'b1);
        drain("drain_horiz");
        check("horiz_count", obs_addr.size(), 1025);
        if (obs_addr.size() == 1025) begin
            check("horiz_first", obs_addr[0], 0);
            check("horiz_mid", obs_addr[512], 512);
            check("horiz_last", obs_addr[1023], 1023);
            check("horiz_wrap", obs_addr[1024], 0);
        end
        check("horiz_frame_done_idx", fd_idx, 1023);

        new_group();
        send_byte(8'h20, 1'b0); send_byte(8'h03, 1'b0);
        send_byte(8'hB3, 1'b0); send_byte(8'h05, 1'b0); send_byte(8'h12, 1'b0);
        send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'h03, 1'b1);
        send_byte(8'h0F, 1'b0); send_byte(8'h17, 1'b0);
        send_byte(8'h04, 1'b1); send_byte(8'h05, 1'b1);
        drain("drain_page");
        check("page_count", obs_addr.size(), 5);
        if (obs_addr.size() == 5) begin
            check("page_w0", obs_addr[0], 'h1A5);
            check("page_w1", obs_addr[1], 'h1A6);
            check("page_w2", obs_addr[2], 'h1A7);
            check("page_w3", obs_addr[3], 'h1FF);
            check("page_w4", obs_addr[4], 'h180);
        end
        check("page_no_frame_done", fd_idx, -1);

        new_group();
        send_byte(8'h20, 1'b0); send_byte(8'h01, 1'b0);
        send_byte(8'h21, 1'b0); send_byte(8'd10, 1'b0); send_byte(8'd11, 1'b0);
        send_byte(8'h22, 1'b0); send_byte(8'd2, 1'b0); send_byte(8'd3, 1'b0);
        for (int i = 0; i < 5; i++) send_byte(8'(8'hC0 + i), 1'b1);
        drain("drain_vert");
        check("vert_count", obs_addr.size(), 5);
        if (obs_addr.size() == 5) begin
            check("vert_w0", obs_addr[0], 266);
            check("vert_w1", obs_addr[1], 394);
            check("vert_w2", obs_addr[2], 267);
            check("vert_w3", obs_addr[3], 395);
            check("vert_w4", obs_addr[4], 266);
        end
        check("vert_frame_done_idx", fd_idx, 3);

        do_reset();
        send_byte(8'hFF, 1'b0, 5);
        repeat (1100) @(negedge clock);
        send_byte(8'hAF, 1'b0);
        drain("drain_timeout");
        check("timeout_display_on", display_on, 1);
        check("timeout_invert", invert, 0);

        do_reset();
        send_byte(8'hFF, 1'b0, 3);
        do_reset();
        send_byte(8'hAF, 1'b0);
        drain("drain_midreset");
        check("midreset_display_on", display_on, 1);

        do_reset();
        new_group();
        send_byte(8'h5A, 1'b1);
        drain("drain_latency");
        check("latency_writes", obs_addr.size(), 1);
        check("latency_clocks", lat, 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
